// File: rtl/cdc_pkg.sv
// cdc_pkg: definitions shared by the pulse-crossing transmitter and its matching receiver.
//   cdc_state_e         - transmitter handshake FSM states
//   CDC_SYNC_STAGES_DEF - default synchronizer depth
package cdc_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } cdc_state_e;

    localparam int unsigned CDC_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: N-stage single-bit synchronizer, asynchronous active-low reset to 0.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input bit
//   q_o    - synchronized bit, STAGES cycles late
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = CDC_SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_pulse_tx.sv
// cdc_pulse_tx: source side of a two-phase (toggle) req/ack pulse crossing.
// Each accepted pulse_i becomes one toggle of req_o; the next event waits until the
// synchronized ack_i level equals req_o.
// Optional feature: define CDC_PULSE_TX_QUEUE_EN to queue events arriving mid-handshake in
// a saturating counter; otherwise such events are dropped.
// Ports:
//   clk_i     - source clock
//   rst_ni    - asynchronous active-low reset
//   pulse_i   - event strobe, one event per high cycle
//   ack_i     - acknowledge toggle from the destination (asynchronous)
//   req_o     - request toggle (registered)
//   busy_o    - handshake outstanding or events queued
//   pending_o - queued events not yet launched (0 without the queue)
//   drop_o    - one-cycle strobe, an event was discarded
module cdc_pulse_tx
    import cdc_pkg::*;
#(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pulse_i,
    input  logic             ack_i,
    output logic             req_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             drop_o
);

    cdc_state_e state_q, state_d;
    logic       req_q, req_d;
    logic       drop_q, drop_d;
    logic       ack_s;
    logic       pend_nz;

`ifdef CDC_PULSE_TX_QUEUE_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] pending_q, pending_d;
`endif

    cdc_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (ack_i),
        .q_o   (ack_s)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        drop_d  = 1'b0;
`ifdef CDC_PULSE_TX_QUEUE_EN
        pending_d = pending_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pulse_i || pend_nz) begin
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
`ifdef CDC_PULSE_TX_QUEUE_EN
                    // With a pulse present a queued event launches and the pulse takes its
                    // slot, so the count only drops when there is no pulse.
                    if (!pulse_i) begin
                        pending_d = pending_q - CntOne;
                    end
`endif
                end
            end
            WAIT_ACK: begin
                if (pulse_i) begin
`ifdef CDC_PULSE_TX_QUEUE_EN
                    if (pending_q == CntMax) begin
                        drop_d = 1'b1;
                    end else begin
                        pending_d = pending_q + CntOne;
                    end
`else
                    drop_d = 1'b1;
`endif
                end
                // Level compare rather than edge detect: a late sample cannot deadlock.
                if (ack_s == req_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

`ifdef CDC_PULSE_TX_QUEUE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend_nz   = |pending_q;
    assign pending_o = pending_q;
`else
    assign pend_nz   = 1'b0;
    assign pending_o = '0;
`endif

    assign req_o  = req_q;
    assign drop_o = drop_q;
    // Derived from registers only; no path from pulse_i.
    assign busy_o = (state_q == WAIT_ACK) | pend_nz;

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// tb_cdc_pulse_tx: directed bench for cdc_pulse_tx. Instance 0 uses CNT_W=4, instance 1
// uses CNT_W=2. A destination responder echoes req back on ack after a delay, optionally
// withheld. An event-accounting model is compared against both instances every cycle.
module tb_cdc_pulse_tx;

    localparam int SYNC = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pulse_v = 2'b00;
    logic [1:0] ack_v   = 2'b00;

    wire        req_a, req_b, busy_a, busy_b, drop_a, drop_b;
    wire  [3:0] pend_a;
    wire  [1:0] pend_b;
    logic [1:0] req_v, busy_v, drop_v;

    assign req_v  = {req_b, req_a};
    assign busy_v = {busy_b, busy_a};
    assign drop_v = {drop_b, drop_a};

    cdc_pulse_tx #(
        .CNT_W      (4),
        .SYNC_STAGES(SYNC)
    ) u_dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .pulse_i  (pulse_v[0]),
        .ack_i    (ack_v[0]),
        .req_o    (req_a),
        .busy_o   (busy_a),
        .pending_o(pend_a),
        .drop_o   (drop_a)
    );

    cdc_pulse_tx #(
        .CNT_W      (2),
        .SYNC_STAGES(SYNC)
    ) u_dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .pulse_i  (pulse_v[1]),
        .ack_i    (ack_v[1]),
        .req_o    (req_b),
        .busy_o   (busy_b),
        .pending_o(pend_b),
        .drop_o   (drop_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d (cycle %0d)", name, i, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- destination responder ----------------
    int  dly[2]  = '{5, 5};
    bit  hold[2] = '{1'b0, 1'b0};
    int  rcnt[2];
    bit  rlast[2];
    int  ack_cyc[2];

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ack_v[i] = 1'b0;
                rcnt[i]  = 0;
                rlast[i] = 1'b0;
            end else begin
                if (req_v[i] != rlast[i]) begin
                    rlast[i] = req_v[i];
                    rcnt[i]  = dly[i];
                end else if (rcnt[i] > 0) begin
                    rcnt[i]--;
                end
                if (!hold[i] && rcnt[i] == 0 && ack_v[i] != req_v[i]) begin
                    ack_v[i]   = req_v[i];
                    ack_cyc[i] = cyc;
                end
            end
        end
    end

    // ---------------- event-accounting model ----------------
    int  maxp[2] = '{15, 3};
    int  m_pend[2];
    bit  m_wait[2];
    bit  m_req[2];
    bit  m_drop[2];
    bit  m_hist[2][SYNC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 0;
                m_wait[i] = 1'b0;
                m_req[i]  = 1'b0;
                m_drop[i] = 1'b0;
                for (int k = 0; k < SYNC; k++) m_hist[i][k] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int avail;
                bit a_s;
                bit launch;
                // Oldest entry is ack_i as sampled SYNC edges ago.
                a_s = m_hist[i][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = ack_v[i];
`ifdef CDC_PULSE_TX_QUEUE_EN
                avail  = m_pend[i] + int'(pulse_v[i]);
                launch = !m_wait[i] && avail > 0;
                if (launch) avail--;
                m_drop[i] = avail > maxp[i];
                if (avail > maxp[i]) avail = maxp[i];
                m_pend[i] = avail;
`else
                launch    = !m_wait[i] && pulse_v[i];
                m_drop[i] = m_wait[i] && pulse_v[i];
                m_pend[i] = 0;
`endif
                if (launch) begin
                    m_req[i]  = !m_req[i];
                    m_wait[i] = 1'b1;
                end else if (m_wait[i] && a_s == m_req[i]) begin
                    m_wait[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and statistics ----------------
    int toggles[2];
    int peak[2];
    int drops[2];
    int fall_cyc[2];
    bit prev_req[2];
    bit prev_busy[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p;
            p = (i == 0) ? int'(pend_a) : int'(pend_b);
            check("req", i, int'(req_v[i]), int'(m_req[i]));
            check("busy", i, int'(busy_v[i]), int'(m_wait[i] || m_pend[i] != 0));
            check("drop", i, int'(drop_v[i]), int'(m_drop[i]));
            check("pending", i, p, m_pend[i]);
            if (req_v[i] != prev_req[i]) toggles[i]++;
            prev_req[i] = req_v[i];
            if (drop_v[i]) drops[i]++;
            if (p > peak[i]) peak[i] = p;
            if (prev_busy[i] && !busy_v[i]) fall_cyc[i] = cyc;
            prev_busy[i] = busy_v[i];
        end
    end

    task automatic clear_stats(input int i);
        toggles[i] = 0;
        peak[i]    = 0;
        drops[i]   = 0;
    endtask

    task automatic wait_idle(input int i, input int lim);
        int n = 0;
        while ((busy_v[i] || req_v[i] != ack_v[i]) && n < lim) begin
            tick();
            n++;
        end
        tick();
        check("drain_busy", i, int'(busy_v[i]), 0);
    endtask

    task automatic pulses(input int i, input int n);
        pulse_v[i] = 1'b1;
        repeat (n) tick();
        pulse_v[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit prev;
        repeat (3) tick();
        check("rst_req", 0, int'(req_a), 0);
        check("rst_busy", 0, int'(busy_a), 0);
        check("rst_pend", 0, int'(pend_a), 0);
        check("rst_drop", 0, int'(drop_a), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single pulse: launch next cycle, busy clears SYNC+1 edges after ack change.
        clear_stats(0);
        pulses(0, 1);
        check("t1_req", 0, int'(req_a), 1);
        check("t1_busy", 0, int'(busy_a), 1);
        wait_idle(0, 100);
        check("t1_latency", 0, fall_cyc[0] - ack_cyc[0], SYNC + 1);
        check("t1_toggles", 0, toggles[0], 1);

`ifdef CDC_PULSE_TX_QUEUE_EN
        // Burst of 5 with 6-cycle echo.
        dly[0] = 6;
        clear_stats(0);
        pulses(0, 5);
        wait_idle(0, 400);
        check("t2_toggles", 0, toggles[0], 5);
        check("t2_peak", 0, peak[0], 4);
        check("t2_drops", 0, drops[0], 0);
        dly[0] = 5;

        // Saturation on the CNT_W=2 instance.
        hold[1] = 1'b1;
        clear_stats(1);
        pulses(1, 6);
        repeat (2) tick();
        check("t3_pend", 1, int'(pend_b), 3);
        check("t3_drops", 1, drops[1], 2);
        hold[1] = 1'b0;
        wait_idle(1, 400);
        check("t3_toggles", 1, toggles[1], 4);

        // Pulse coinciding with a queued launch from IDLE.
        hold[0] = 1'b1;
        pulses(0, 3);
        repeat (2) tick();
        check("t4_pend_pre", 0, int'(pend_a), 2);
        hold[0] = 1'b0;
        n = 0;
        while (!(!m_wait[0] && m_pend[0] != 0) && n < 60) begin
            tick();
            n++;
        end
        prev = req_a;
        pulses(0, 1);
        check("t4_pend", 0, int'(pend_a), 2);
        check("t4_toggle", 0, int'(req_a), int'(!prev));
        wait_idle(0, 400);
`else
        // Without the queue, pulses during WAIT_ACK are dropped.
        hold[0] = 1'b1;
        clear_stats(0);
        pulses(0, 1);
        tick();
        pulses(0, 3);
        repeat (2) tick();
        check("t6_drops", 0, drops[0], 3);
        check("t6_pend", 0, int'(pend_a), 0);
        hold[0] = 1'b0;
        wait_idle(0, 100);
        check("t6_toggles", 0, toggles[0], 1);
`endif

        // Reset in WAIT_ACK with events queued.
        hold[0] = 1'b1;
        pulses(0, 3);
        repeat (2) tick();
        check("t5_busy_pre", 0, int'(busy_a), 1);
`ifdef CDC_PULSE_TX_QUEUE_EN
        check("t5_pend_pre", 0, int'(pend_a), 2);
`endif
        rst_n = 1'b0;
        #1;
        check("t5_req", 0, int'(req_a), 0);
        check("t5_busy", 0, int'(busy_a), 0);
        check("t5_pend", 0, int'(pend_a), 0);
        check("t5_drop", 0, int'(drop_a), 0);
        hold[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        pulses(0, 1);
        check("t5_relaunch_req", 0, int'(req_a), 1);
        check("t5_relaunch_busy", 0, int'(busy_a), 1);
        wait_idle(0, 100);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
